// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU's single-port memory between instruction fetch (IF) and data (D), with watchdog abort.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants on a tie instead of always favouring D.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  output logic          err_src
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            owner_q, owner_d;      // 0 = IF, 1 = D
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            if_ack_q, if_ack_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            err_q, err_d;
  logic            err_src_q, err_src_d;
  logic            pick;
  logic            finish;
  logic [DW-1:0]   rdata_v;

`ifdef ARB_ROUND_ROBIN_EN
  logic            last_grant_q, last_grant_d;
  assign pick = (if_req && d_req) ? ~last_grant_q : d_req;
`else
  assign pick = d_req;
`endif

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
    err_src_d   = err_src_q;
    finish      = 1'b0;
    rdata_v     = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d     = S_WAIT;
          owner_d     = pick;
          wd_d        = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = pick & d_we;
          mem_addr_d  = pick ? d_addr : if_addr;
          mem_wdata_d = pick ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = pick;
`endif
        end
      end
      S_WAIT: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        if (mem_ack) begin
          finish  = 1'b1;
          rdata_v = mem_we_q ? '0 : mem_rdata;
        end else if ((TIMEOUT != 0) && (int'(wd_q) + 1 == TIMEOUT)) begin
          // Abort on the edge the watchdog would reach TIMEOUT: mem_req stays up exactly TIMEOUT cycles.
          finish    = 1'b1;
          err_d     = 1'b1;
          err_src_d = owner_q;
        end
        if (finish) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (owner_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = rdata_v;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = rdata_v;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;   // requests ignored here so a held req is not re-granted during its ack
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      err_src_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      err_src_q   <= err_src_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign err_src   = err_src_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;
  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit FIRST_D = 1'b0;
`else
  localparam bit FIRST_D = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_ack, d_ack, mem_req, mem_we, err, err_src;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err), .err_src(err_src)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, counted in cycles since grant.
  bit          m_busy = 0, m_done = 0, m_owner = 0, m_last = 1;
  int          m_cnt = 0;
  logic        e_mem_req = 0, e_mem_we = 0, e_if_ack = 0, e_d_ack = 0, e_err = 0, e_err_src = 0;
  logic [31:0] e_mem_addr = '0, e_mem_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_owner = 0; m_last = 1; m_cnt = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_if_ack = 0; e_d_ack = 0; e_if_rdata = '0; e_d_rdata = '0;
      e_err = 0; e_err_src = 0;
    end else if (m_done) begin
      m_done = 0; e_if_ack = 0; e_d_ack = 0; e_err = 0;
    end else if (!m_busy) begin
      if (if_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_owner = (if_req && d_req) ? !m_last : d_req;
        m_last  = m_owner;
`else
        m_owner = d_req;
`endif
        m_busy = 1; m_cnt = 0;
        e_mem_req   = 1;
        e_mem_we    = m_owner && d_we;
        e_mem_addr  = m_owner ? d_addr : if_addr;
        e_mem_wdata = d_wdata;
      end
    end else begin
      bit ab;
      logic [31:0] rd;
      m_cnt++;
      ab = !mem_ack && (m_cnt == TO);
      if (mem_ack || ab) begin
        rd = (ab || e_mem_we) ? 32'h0 : mem_rdata;
        m_busy = 0; m_done = 1; e_mem_req = 0;
        if (m_owner) begin e_d_ack = 1; e_d_rdata = rd; end
        else begin e_if_ack = 1; e_if_rdata = rd; end
        if (ab) begin e_err = 1; e_err_src = m_owner; end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc mem_req",  mem_req,  e_mem_req);
    check("cyc if_ack",   if_ack,   e_if_ack);
    check("cyc d_ack",    d_ack,    e_d_ack);
    check("cyc if_rdata", if_rdata, e_if_rdata);
    check("cyc d_rdata",  d_rdata,  e_d_rdata);
    check("cyc err",      err,      e_err);
    check("cyc err_src",  err_src,  e_err_src);
    if (e_mem_req) begin
      check("cyc mem_we",   mem_we,   e_mem_we);
      check("cyc mem_addr", mem_addr, e_mem_addr);
      if (e_mem_we) check("cyc mem_wdata", mem_wdata, e_mem_wdata);
    end
  end

  // Memory responder: ack after ack_delay cycles of mem_req; -1 means never.
  int ack_delay = 0;
  int seen = 0;
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      mem_ack = (seen == ack_delay);
      seen++;
    end else begin
      mem_ack = 1'b0;
      seen = 0;
    end
  end

  int   req_pulses = 0, req_hi = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (mem_req && !prev_req) req_pulses++;
    if (mem_req) req_hi++;
    prev_req = mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input bit is_d, input int limit, output int lat);
    string nm;
    nm = is_d ? "d_ack seen" : "if_ack seen";
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(is_d ? d_ack : if_ack) && lat < limit);
    check(nm, is_d ? d_ack : if_ack, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    bit own[2];

    #1 reset_n = 1'b0;
    #1;
    check("reset mem_req", mem_req, 0);
    check("reset if_ack",  if_ack,  0);
    check("reset d_ack",   d_ack,   0);
    check("reset err",     err,     0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    // 1: IF read, memory answers two cycles after mem_req.
    ack_delay = 2; mem_rdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h10;
    tick();
    check("t1 mem_req",  mem_req,  1);
    check("t1 mem_addr", mem_addr, 32'h10);
    check("t1 mem_we",   mem_we,   0);
    wait_ack(0, 20, lat);
    check("t1 latency",  lat, 3);
    check("t1 if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1 err",      err, 0);
    if_req = 0;
    repeat (2) tick();

    // 2a: tie, each requester drops after its own ack.
    ack_delay = 0; mem_rdata = 32'hCAFEF00D;
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    tick();
    check("t2 first mem_we",   mem_we,   FIRST_D);
    check("t2 first mem_addr", mem_addr, FIRST_D ? 32'h20 : 32'h40);
`ifndef ARB_ROUND_ROBIN_EN
    check("t2 first mem_wdata", mem_wdata, 32'h12345678);
`endif
    wait_ack(FIRST_D, 10, lat);
    check("t2 first latency", lat, 1);
    if (FIRST_D) d_req = 0; else if_req = 0;
    wait_ack(!FIRST_D, 10, lat);
    check("t2 second gap", lat, 3);
    check("t2 d_rdata write", d_rdata, 0);
    check("t2 if_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 0; d_req = 0;
    repeat (2) tick();

    // 2b: tie with both held across two grants.
    if_req = 1; d_req = 1;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      tick();
      check("t2b no double ack", if_ack && d_ack, 0);
      if (if_ack || d_ack) begin
        own[n] = d_ack;
        n++;
      end
    end
    if_req = 0; d_req = 0;
    check("t2b ack count", n, 2);
    check("t2b first owner",  own[0], FIRST_D);
    check("t2b second owner", own[1], 1);
    repeat (2) tick();

    // 4: async reset mid-WAIT, then fresh grant after release.
    ack_delay = -1;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    repeat (3) tick();
    check("t4 in wait", mem_req, 1);
    reset_n = 1'b0;
    #1;
    check("t4 rst mem_req",  mem_req,  0);
    check("t4 rst mem_addr", mem_addr, 0);
    check("t4 rst if_rdata", if_rdata, 0);
    check("t4 rst d_ack",    d_ack,    0);
    ack_delay = 0; mem_rdata = 32'h0BADF00D;
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    check("t4 regrant mem_req",  mem_req,  1);
    check("t4 regrant mem_addr", mem_addr, 32'h100);
    wait_ack(1, 10, lat);
    check("t4 latency", lat, 1);
    check("t4 d_rdata", d_rdata, 32'h0BADF00D);
    d_req = 0;
    repeat (2) tick();

    // 3: D read never acknowledged -> watchdog abort after TO cycles.
    ack_delay = -1; mem_rdata = 32'h55AA55AA;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    req_hi = 0;
    wait_ack(1, 30, lat);
    check("t3 latency",  lat, 9);
    check("t3 req_hi",   req_hi, TO);
    check("t3 d_rdata",  d_rdata, 0);
    check("t3 err",      err, 1);
    check("t3 err_src",  err_src, 1);
    d_req = 0;
    tick();
    check("t3 err pulse", err, 0);
    check("t3 err_src hold", err_src, 1);
    tick();

    // 5: IF held for four back-to-back transactions.
    ack_delay = 0; mem_rdata = 32'h00C0FFEE;
    req_pulses = 0;
    if_req = 1; if_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, 10, lat);
      check("t5 ack spacing", lat, (k == 0) ? 2 : 3);
      if (k == 3) if_req = 0;
    end
    repeat (4) tick();
    check("t5 mem_req pulses", req_pulses, 4);
    check("t5 if_rdata", if_rdata, 32'h00C0FFEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
